vc_plane_scheduler: RTL
=======================

# vc_plane_scheduler

- Packet-level scheduler for the VC demux stage of a router input.
- Chooses which VC plane the incoming flit bundle is steered into and drives the demux plane selector.
- Gates the upstream valid/ready handshake so flits move only while a plane is locked.
- Holds the lock from head flit to tail flit; rotates planes round-robin among free VCs, with a stall timeout against deadlock.

## Interface
- VC, 4, number of VC planes (≥2)
- INPUTS, 4, lanes per bundle
- MAX_HOLD, 16, locked cycles with no transfer before forced release; 0 disables the timeout
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous and active-low
- valid_in_bus  input  INPUTS  upstream lane valids
- ready_in_bus  output  INPUTS  upstream lane readys
- tail_in  input  1  current bundle carries the packet's tail flit
- vc_free  input  VC  plane i can accept a new packet
- valid_out_bus  output  INPUTS  to demux valid_in_bus
- ready_out_bus  input  INPUTS  from demux ready_in_bus
- VCPlaneSelector  output  VC+1  plane index to demux, zero-extended
- locked  output  1  a plane is currently granted
- timeout  output  1  one-cycle pulse on forced release

## Operation
- Two states:
  - IDLE: locked=0; valid_out_bus=0; ready_in_bus=0; VCPlaneSelector holds its last value.
  - LOCKED: valid_out_bus=valid_in_bus; ready_in_bus=ready_out_bus.
- Registers:
  - state
  - sel: VC+1 bits, drives VCPlaneSelector
  - last: index of the last granted plane
  - hold_cnt: width $clog2(MAX_HOLD+1)
- Grant (IDLE):
  - Condition: |valid_in_bus and |vc_free.
  - Search vc_free starting at (last+1) mod VC, wrapping; the first set bit wins.
  - Register the winner into sel and last; go to LOCKED.
  - No valid or no free plane: remain IDLE and keep the pointer.
- Transfer: fire = locked & |(valid_in_bus & ready_out_bus).
- Tail release: fire & tail_in → IDLE next cycle.
- Stall counter, in LOCKED:
  - fire clears hold_cnt; otherwise hold_cnt increments.
  - When MAX_HOLD≠0 and hold_cnt==MAX_HOLD-1 with no fire: → IDLE and timeout=1 for that next cycle.
  - hold_cnt clears on every entry to IDLE.
- vc_free changes during LOCKED are ignored; only tail or timeout releases the lock.
- No grant is issued in the release cycle; every packet boundary costs at least one IDLE cycle.
- Reset values: state=IDLE; sel=0; last=VC-1, so the first grant searches from plane 0; hold_cnt=0; locked=0; timeout=0; valid_out_bus=0; ready_in_bus=0.

## Timing
- Grant latency: request sampled in IDLE at edge N → locked=1 and new sel visible after edge N. First flit transfer is possible in cycle N+1.
- valid_out_bus and ready_in_bus are combinational from state and inputs, with no added latency.
- Release: tail fire in cycle M → locked=0 from M+1. Earliest next grant decision is at edge M+1; the next LOCKED cycle is M+2.
- Timeout: the last stalled cycle is at hold_cnt=MAX_HOLD-1, so the lock is held for exactly MAX_HOLD cycles with no fire. timeout is high only in the first IDLE cycle.
- Tail fire and timeout in the same cycle: tail wins and timeout stays 0 (fire clears the stall path).
- Single free plane: the search may select last again; this is legal.
- Reset asserted mid-packet: all state clears immediately and asynchronously. Outputs take reset values with no clock; the interrupted packet is dropped from the handshake view.
- VCPlaneSelector always holds a value in 0..VC-1.

## Test plan
- Reset, then valid_in_bus=4'b0011 and vc_free=4'b1111 → locked=1 after 1 edge, VCPlaneSelector=0, and ready_in_bus follows ready_out_bus.
- Three back-to-back single-flit packets (tail_in=1, ready_out_bus all ones) with all planes free → selectors 0,1,2, each packet separated by exactly one IDLE cycle.
- vc_free=4'b1000 after a grant to plane 1 → next grant is 3. vc_free=4'b0010 → next grant is 1 again.
- MAX_HOLD=4, locked, ready_out_bus=0 → after 4 locked cycles, locked=0 and a one-cycle timeout pulse; no flit is accepted meanwhile.
- 3-flit packet on plane 2; drop vc_free[2] mid-packet → lock holds until the tail fire; then release and the next grant searches from 3.
- Assert rst low while locked with a stall count of 2 → locked, timeout, valid_out_bus and VCPlaneSelector are 0 immediately. After release, the next grant goes to plane 0.

Source files
------------

// File: rtl/vc_plane_scheduler.sv
// VC plane scheduler: locks one demux plane per packet (head to tail), picks planes
// round-robin among free VCs, and force-releases a lock that stalls for MAX_HOLD cycles.
module vc_plane_scheduler #(
    parameter int VC       = 4,
    parameter int INPUTS   = 4,
    parameter int MAX_HOLD = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [INPUTS-1:0] valid_in_bus,
    output logic [INPUTS-1:0] ready_in_bus,
    input  logic              tail_in,
    input  logic [VC-1:0]     vc_free,
    output logic [INPUTS-1:0] valid_out_bus,
    input  logic [INPUTS-1:0] ready_out_bus,
    output logic [VC:0]       VCPlaneSelector,
    output logic              locked,
    output logic              timeout
);

    localparam int LW = (VC > 1) ? $clog2(VC) : 1;
    localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
    localparam logic [LW-1:0] LAST_RST  = LW'(VC - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [VC:0]     sel_q, sel_d;
    logic [LW-1:0]   last_q, last_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic            timeout_q, timeout_d;

    logic            fire;
    logic            grant_found;
    logic [LW-1:0]   grant_idx;

    assign locked          = (state_q == LOCKED);
    assign fire            = locked & (|(valid_in_bus & ready_out_bus));
    assign valid_out_bus   = locked ? valid_in_bus  : '0;
    assign ready_in_bus    = locked ? ready_out_bus : '0;
    assign VCPlaneSelector = sel_q;
    assign timeout         = timeout_q;

    // Round-robin search: start one past the last grant, wrap, first free plane wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = last_q;
        for (int i = 1; i <= VC; i++) begin
            int            sum;
            logic [LW-1:0] cand;
            sum = int'(last_q) + i;
            if (sum >= VC) sum = sum - VC;
            cand = LW'(sum);
            if (!grant_found && vc_free[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        last_d    = last_q;
        hold_d    = hold_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                hold_d = '0;
                if ((|valid_in_bus) && grant_found) begin
                    state_d           = LOCKED;
                    sel_d             = '0;
                    sel_d[LW-1:0]     = grant_idx;
                    last_d            = grant_idx;
                end
            end
            LOCKED: begin
                // A transfer always beats the stall path, so tail and timeout never coincide.
                if (fire) begin
                    hold_d = '0;
                    if (tail_in) state_d = IDLE;
                end else if ((MAX_HOLD != 0) && (hold_q == HOLD_LAST)) begin
                    state_d   = IDLE;
                    hold_d    = '0;
                    timeout_d = 1'b1;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            last_q    <= LAST_RST;
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            last_q    <= last_d;
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

endmodule
